fsmc_buffer_bridge: RTL and testbench

- Parametrised STM32 FSMC asynchronous-SRAM slave giving the MCU windowed access to an on-FPGA buffer RAM.
- Small register map: index pointer, auto-increment data port, non-incrementing data port, status/control.
- Adds strobe synchronisation, bus turnaround that drives only during a qualified read, and pointer wrap detection.
- Instantiated in the FPGA top, directly on the FSMC pins; application logic uses the status outputs.

---
 rtl/fsmc_buffer_bridge_if.sv | 22 ++
 rtl/fsmc_buffer_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_fsmc_buffer_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsmc_buffer_bridge_if.sv
// FSMC strobe and register-select bundle.
// The data bus stays a plain inout on the bridge.
interface fsmc_buffer_bridge_if;
  logic       nce;
  logic       noe;
  logic       nwe;
  logic [1:0] addr;

  modport master (
    output nce,
    output noe,
    output nwe,
    output addr
  );

  modport slave (
    input nce,
    input noe,
    input nwe,
    input addr
  );
endinterface

// File: rtl/fsmc_buffer_bridge.sv
// FSMC async-SRAM slave giving the MCU a
// pointer-windowed view of an on-FPGA buffer RAM.
module fsmc_buffer_bridge #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 512,
  parameter int SYNC_STAGES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fsmc_buffer_bridge_if.slave      bus,
  inout  wire  [DATA_W-1:0]        data,
  output logic [$clog2(DEPTH)-1:0] index,
  output logic                     wrapped,
  output logic                     activity
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int L     = SYNC_STAGES - 1;
  localparam int P     = SYNC_STAGES - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] nce_s;
  logic [SYNC_STAGES-1:0] noe_s;
  logic [SYNC_STAGES-1:0] nwe_s;

  logic nce_q;
  logic nce_n;
  logic noe_q;
  logic nwe_q;
  logic noe_fall;
  logic noe_rise;
  logic nwe_fall;
  logic nwe_rise;

  logic commit;
  logic rd_start;
  logic rd_done;
  logic bus_oe;

  logic [DATA_W-1:0] cap_data;
  logic [1:0]        cap_addr;
  logic [1:0]        rd_addr;
  logic              rd_pend;
  logic [DATA_W-1:0] rd_latch;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] idx_ext;
  logic [DATA_W-1:0] status;
  logic [IDX_W-1:0]  wr_idx;

  logic inc;
  logic set_wrap;
  logic clr_wrap;
  logic ram_we;
  logic ram_rd;
  logic a_idx;
  logic a_ram;
  logic a_sts;

  logic [DATA_W-1:0] mem [DEPTH];

  // Strobes idle high, so the synchronisers reset to ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nce_s <= '1;
      noe_s <= '1;
      nwe_s <= '1;
    end else begin
      nce_s <= {nce_s[P:0], bus.nce};
      noe_s <= {noe_s[P:0], bus.noe};
      nwe_s <= {nwe_s[P:0], bus.nwe};
    end
  end

  assign nce_q    = nce_s[L];
  assign nce_n    = nce_s[P];
  assign noe_q    = noe_s[L];
  assign nwe_q    = nwe_s[L];
  assign noe_fall = noe_s[L] & ~noe_s[P];
  assign noe_rise = ~noe_s[L] & noe_s[P];
  assign nwe_fall = nwe_s[L] & ~nwe_s[P];
  assign nwe_rise = ~nwe_s[L] & nwe_s[P];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe start qualifies on the newer nce stage so a
  // chip select that falls together with the strobe counts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (nwe_fall && !nce_n) begin
          state_d = S_WR;
        end else if (noe_fall && !nce_n) begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (nwe_rise || nce_q) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (noe_rise || nce_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    commit   = (state_q == S_WR) && nwe_rise;
    rd_start = (state_q == S_IDLE) && (state_d == S_RD);
    rd_done  = (state_q == S_RD) && noe_rise;
    bus_oe   = (state_q == S_RD) && !noe_q && !nce_q;
  end

  assign data = bus_oe ? rd_latch : 'z;

  generate
    if (IDX_W >= DATA_W) begin : g_ext_trunc
      assign idx_ext = index[DATA_W-1:0];
    end else begin : g_ext_pad
      assign idx_ext = {{(DATA_W-IDX_W){1'b0}}, index};
    end
    if (IDX_W <= DATA_W) begin : g_idx_trunc
      assign wr_idx = cap_data[IDX_W-1:0];
    end else begin : g_idx_pad
      assign wr_idx = {{(IDX_W-DATA_W){1'b0}}, cap_data};
    end
  endgenerate

  assign status = {wrapped, idx_ext[DATA_W-2:0]};

  always_comb begin
    a_idx    = (bus.addr == 2'd0);
    a_sts    = (bus.addr == 2'd3);
    a_ram    = !a_idx && !a_sts;
    inc      = (commit && cap_addr == 2'd1)
             || (rd_done && rd_addr == 2'd1);
    set_wrap = inc && (index == IDX_W'(DEPTH - 1));
    clr_wrap = commit && (cap_addr == 2'd3)
             && cap_data[0];
    ram_we   = commit && (cap_addr == 2'd1
             || cap_addr == 2'd2);
    ram_rd   = rd_start && a_ram;
  end

  // The last sample taken while nwe is low is what commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data <= '0;
      cap_addr <= '0;
    end else if (!nwe_q) begin
      cap_data <= data;
      cap_addr <= bus.addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index    <= '0;
      wrapped  <= 1'b0;
      activity <= 1'b0;
    end else begin
      activity <= commit || rd_done;
      if (commit && cap_addr == 2'd0) begin
        index <= wr_idx;
      end else if (inc) begin
        index <= index + IDX_W'(1);
      end
      if (set_wrap) begin
        wrapped <= 1'b1;
      end else if (clr_wrap) begin
        wrapped <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      rd_pend  <= 1'b0;
      rd_latch <= '0;
    end else if (rd_start) begin
      rd_addr <= bus.addr;
      rd_pend <= a_ram;
      unique case (1'b1)
        a_idx:   rd_latch <= idx_ext;
        a_sts:   rd_latch <= status;
        a_ram:   rd_latch <= rd_latch;
        default: rd_latch <= rd_latch;
      endcase
    end else if (rd_pend) begin
      rd_pend  <= 1'b0;
      rd_latch <= ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[index] <= cap_data;
    end
    if (ram_rd) begin
      ram_q <= mem[index];
    end
  end

endmodule

// File: tb/tb_fsmc_buffer_bridge.sv
// Scoreboard bench for fsmc_buffer_bridge: FSMC
// bus tasks, expected reads queued, popped on sample.
module tb_fsmc_buffer_bridge;

  localparam int DW = 16;
  localparam int DEP = 512;
  localparam int SYN = 3;
  localparam int IW = $clog2(DEP);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_oe = 1'b0;
  logic [DW-1:0] tb_dat = '0;
  wire  [DW-1:0] data;
  logic [IW-1:0] index;
  logic wrapped;
  logic activity;

  int checks = 0;
  int fails = 0;
  int act_cnt = 0;
  int oe_cnt = 0;
  int exp_act = 0;
  int oe_base;
  logic [DW-1:0] exp_q [$];

  fsmc_buffer_bridge_if bus ();

  assign data = tb_oe ? tb_dat : 'z;

  fsmc_buffer_bridge #(
    .DATA_W(DW),
    .DEPTH(DEP),
    .SYNC_STAGES(SYN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .data(data),
    .index(index),
    .wrapped(wrapped),
    .activity(activity)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (activity) act_cnt++;
    if (dut.bus_oe) oe_cnt++;
  end

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(
    input logic [1:0] a,
    input logic [DW-1:0] d,
    input logic ce
  );
    @(negedge clk);
    bus.addr = a;
    tb_dat = d;
    tb_oe = 1'b1;
    bus.nce = ce;
    @(negedge clk);
    bus.nwe = 1'b0;
    repeat (4) @(negedge clk);
    bus.nwe = 1'b1;
    repeat (SYN + 3) @(negedge clk);
    tb_oe = 1'b0;
    bus.nce = 1'b1;
    repeat (2) @(negedge clk);
    if (!ce) exp_act++;
  endtask

  task automatic bus_read(
    input logic [1:0] a,
    input logic [DW-1:0] exp,
    input string tag
  );
    exp_q.push_back(exp);
    @(negedge clk);
    bus.addr = a;
    bus.nce = 1'b0;
    bus.noe = 1'b0;
    repeat (SYN + 3) @(negedge clk);
    check({tag, "_oe"}, 32'(dut.bus_oe), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      check(tag, 32'(data), 32'(exp_q.pop_front()));
    end
    bus.noe = 1'b1;
    bus.nce = 1'b1;
    repeat (SYN + 3) @(negedge clk);
    check({tag, "_hiz"}, 32'(dut.bus_oe), 32'd0);
    exp_act++;
  endtask

  initial begin
    bus.nce = 1'b1;
    bus.noe = 1'b1;
    bus.nwe = 1'b1;
    bus.addr = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_index", 32'(index), 32'd0);
    check("rst_wrap", 32'(wrapped), 32'd0);
    check("rst_act", 32'(activity), 32'd0);
    check("rst_oe", 32'(dut.bus_oe), 32'd0);

    // Reset during a driven read
    bus_write(2'd0, 16'h01FF, 1'b0);
    bus_write(2'd1, 16'h0777, 1'b0);
    check("pre_wrap", 32'(wrapped), 32'd1);
    bus_write(2'd0, 16'h0033, 1'b0);
    @(negedge clk);
    bus.addr = 2'd0;
    bus.nce = 1'b0;
    bus.noe = 1'b0;
    repeat (SYN + 3) @(negedge clk);
    check("mid_oe", 32'(dut.bus_oe), 32'd1);
    check("mid_data", 32'(data), 32'h0033);
    rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(dut.bus_oe), 32'd0);
    check("arst_index", 32'(index), 32'd0);
    check("arst_wrap", 32'(wrapped), 32'd0);
    bus.noe = 1'b1;
    bus.nce = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(2'd0, 16'h0000, "idx_after_rst");

    // Auto-increment writes
    bus_write(2'd0, 16'h0010, 1'b0);
    bus_write(2'd1, 16'hA5A5, 1'b0);
    bus_write(2'd1, 16'h5A5A, 1'b0);
    check("wr_index", 32'(index), 32'h012);

    // Auto-increment reads
    bus_write(2'd0, 16'h0010, 1'b0);
    bus_read(2'd1, 16'hA5A5, "rd1_a");
    bus_read(2'd1, 16'h5A5A, "rd1_b");
    check("rd_index", 32'(index), 32'h012);

    // Wrap, status and clear
    bus_write(2'd0, 16'h01FF, 1'b0);
    bus_write(2'd1, 16'hBEEF, 1'b0);
    check("wrap_index", 32'(index), 32'd0);
    check("wrap_set", 32'(wrapped), 32'd1);
    bus_read(2'd3, 16'h8000, "sts_wrap");
    bus_write(2'd3, 16'h0001, 1'b0);
    check("wrap_clr", 32'(wrapped), 32'd0);
    bus_read(2'd3, 16'h0000, "sts_clr");
    bus_write(2'd0, 16'h0000, 1'b0);
    check("idx0_nowrap", 32'(wrapped), 32'd0);

    // Non-incrementing port
    bus_write(2'd0, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd2, 16'hA5A5, "rd2");
    end
    check("rd2_index", 32'(index), 32'h010);

    // Strobes with chip select high
    oe_base = oe_cnt;
    bus_write(2'd0, 16'h0055, 1'b1);
    bus_write(2'd1, 16'hDEAD, 1'b1);
    @(negedge clk);
    bus.addr = 2'd1;
    bus.noe = 1'b0;
    repeat (SYN + 3) @(negedge clk);
    check("nce_rd_oe", 32'(dut.bus_oe), 32'd0);
    bus.noe = 1'b1;
    repeat (SYN + 3) @(negedge clk);
    check("nce_index", 32'(index), 32'h010);
    check("nce_act", 32'(act_cnt), 32'(exp_act));
    check("nce_oe_cnt", 32'(oe_cnt), 32'(oe_base));
    bus_read(2'd2, 16'hA5A5, "nce_ram");

    // Chip select drops mid write strobe
    @(negedge clk);
    bus.addr = 2'd1;
    tb_dat = 16'h1111;
    tb_oe = 1'b1;
    bus.nce = 1'b0;
    @(negedge clk);
    bus.nwe = 1'b0;
    repeat (4) @(negedge clk);
    bus.nce = 1'b1;
    repeat (SYN + 3) @(negedge clk);
    bus.nwe = 1'b1;
    repeat (SYN + 3) @(negedge clk);
    tb_oe = 1'b0;
    check("abort_index", 32'(index), 32'h010);
    check("abort_act", 32'(act_cnt), 32'(exp_act));
    bus_read(2'd2, 16'hA5A5, "abort_ram");
    bus_read(2'd0, 16'h0010, "idx_rd");

    repeat (3) @(negedge clk);
    check("act_total", 32'(act_cnt), 32'(exp_act));
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
